// File: rtl/truth_table_scanner_pkg.sv
// rtl/truth_table_scanner_pkg.sv - shared state encodings and default constants for the scanner
package truth_table_scanner_pkg;

   localparam int N_IN_DEFAULT          = 5;
   localparam int SETTLE_CYCLES_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } scan_state_e;

   // Counter width able to hold SETTLE_CYCLES; never narrower than one bit.
   function automatic int settle_cnt_width(input int settle_cycles);
      return (settle_cycles > 0) ? $clog2(settle_cycles + 1) : 1;
   endfunction

endpackage

// File: rtl/truth_table_scanner_settle.sv
// rtl/truth_table_scanner_settle.sv - loadable down-counter timing the settle interval of each code
module settle_counter #(
   parameter int            W        = 2,
   parameter logic [W-1:0]  LOAD_VAL = '0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Load wins over counting; the count parks at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - walks every input code of a combinational block and captures its truth table
module truth_table_scanner #(
   parameter int N_IN          = truth_table_scanner_pkg::N_IN_DEFAULT,
   parameter int SETTLE_CYCLES = truth_table_scanner_pkg::SETTLE_CYCLES_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 y_in,
   output logic [N_IN-1:0]      x_out,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   table_out,
   output logic [N_IN:0]        ones_count
);

   import truth_table_scanner_pkg::*;

   localparam int              TW     = 2**N_IN;
   localparam int              CW     = settle_cnt_width(SETTLE_CYCLES);
   localparam logic [CW-1:0]   LOAD   = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [N_IN-1:0] X_LAST = '1;
   // With no settle time each code goes straight to its sample cycle.
   localparam scan_state_e     FIRST  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

   scan_state_e     state_q, state_d;
   logic [N_IN-1:0] x_q, x_d;
   logic [TW-1:0]   table_q, table_d;
   logic [N_IN:0]   ones_q, ones_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            cnt_load;
   logic            cnt_en;
   logic            cnt_zero;

   settle_counter #(
      .W        (CW),
      .LOAD_VAL (LOAD)
   ) u_settle (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cnt_load),
      .en    (cnt_en),
      .zero  (cnt_zero)
   );

   assign cnt_en = (state_q == SETTLE);

   // Next-state, code stepping and result capture.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      table_d  = table_q;
      ones_d   = ones_q;
      cnt_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d  = FIRST;
               x_d      = '0;
               table_d  = '0;
               ones_d   = '0;
               cnt_load = 1'b1;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_d = IDLE;
               x_d     = '0;
            end else if (cnt_zero) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            if (abort) begin
               // Partial results stay visible; this code is not sampled.
               state_d = IDLE;
               x_d     = '0;
            end else begin
               table_d[x_q] = y_in;
               ones_d       = ones_q + {{N_IN{1'b0}}, y_in};
               if (x_q != X_LAST) begin
                  x_d      = x_q + N_IN'(1);
                  state_d  = FIRST;
                  cnt_load = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
      done_d = (state_d == DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         table_q <= '0;
         ones_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         table_q <= table_d;
         ones_q  <= ones_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign x_out      = x_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign table_out  = table_q;
   assign ones_count = ones_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - directed scoreboard bench for truth_table_scanner
module tb_truth_table_scanner;

   typedef struct {
      int          g;
      logic [31:0] tbl;
      int          ones;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start_v    [3];
   logic        abort_v    [3];
   logic        y_in_v     [3];
   logic [4:0]  x_out_v    [3];
   logic        busy_v     [3];
   logic        done_v     [3];
   logic [31:0] table_v    [3];
   logic [5:0]  ones_v     [3];
   logic        dly_q      [3];
   int          mode_v     [3];

   exp_t        sb[$];
   int          n_checks;
   int          n_err;

   // Instance 0 uses the default settle time, 1 has none, 2 has one cycle.
   function automatic int settle_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 0 : 1);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int S = (g == 0) ? 2 : ((g == 1) ? 0 : 1);
      truth_table_scanner #(
         .N_IN          (5),
         .SETTLE_CYCLES (S)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .start      (start_v[g]),
         .abort      (abort_v[g]),
         .y_in       (y_in_v[g]),
         .x_out      (x_out_v[g]),
         .busy       (busy_v[g]),
         .done       (done_v[g]),
         .table_out  (table_v[g]),
         .ones_count (ones_v[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Function-under-test models: 0 = x[0], 1 = AND of x, 2 = constant 1, 3 = x[0] one register late.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         y_in_v[i] = 1'b0;
         case (mode_v[i])
            0:       y_in_v[i] = x_out_v[i][0];
            1:       y_in_v[i] = &x_out_v[i];
            2:       y_in_v[i] = 1'b1;
            default: y_in_v[i] = dly_q[i];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) dly_q[i] <= 1'b0;
         else        dly_q[i] <= x_out_v[i][0];
      end
   end

   function automatic exp_t model(input int g, input int mode, input int s,
                                  input logic prev_b0, input int ncodes);
      exp_t e;
      logic y;
      e.g    = g;
      e.tbl  = '0;
      e.ones = 0;
      for (int k = 0; k < ncodes; k++) begin
         case (mode)
            0:       y = (k % 2) == 1;
            1:       y = (k == 31);
            2:       y = 1'b1;
            default: begin
               if (s == 0) y = (k == 0) ? prev_b0 : (((k - 1) % 2) == 1);
               else        y = (k % 2) == 1;
            end
         endcase
         e.tbl[k] = y;
         e.ones   = e.ones + (y ? 1 : 0);
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_compare(input int g, input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_table"}, table_v[g], e.tbl);
         check({tag, "_ones"}, {26'd0, ones_v[g]}, e.ones);
      end
   endtask

   // Full scan: start at edge 0, then track busy/done cycle numbers until a few cycles after done.
   task automatic do_scan(input int g, input int mode, input logic prev_b0,
                          input bit hold, input int pulse_at, input string tag);
      int s, n, lim, first_b, last_b, nbusy, done_c, done_n, pulsed;
      s        = settle_of(g);
      n        = 32 * (s + 1);
      lim      = n + 4;
      mode_v[g] = mode;
      sb.push_back(model(g, mode, s, prev_b0, 32));
      start_v[g] = 1'b1;
      tick();
      if (!hold) start_v[g] = 1'b0;
      first_b = -1; last_b = -1; nbusy = 0; done_c = -1; done_n = 0; pulsed = 0;
      for (int c = 1; c <= lim; c++) begin
         if (busy_v[g]) begin
            if (first_b < 0) first_b = c;
            last_b = c;
            nbusy++;
         end
         if (done_v[g]) begin
            done_n++;
            if (done_c < 0) begin
               done_c = c;
               pop_compare(g, tag);
            end
         end
         if (pulse_at >= 0) begin
            if (pulsed == 1) begin
               start_v[g] = 1'b1;
               pulsed = 2;
            end else if (pulsed == 0 && x_out_v[g] == 5'(pulse_at)) begin
               start_v[g] = 1'b0;
               pulsed = 1;
            end
         end
         if (hold && done_c >= 0 && c == done_c + 1) start_v[g] = 1'b0;
         tick();
      end
      if (done_c < 0 && sb.size() > 0) void'(sb.pop_front());
      start_v[g] = 1'b0;
      check({tag, "_first_busy"}, first_b, 1);
      check({tag, "_last_busy"}, last_b, n);
      check({tag, "_busy_cycles"}, nbusy, n);
      check({tag, "_done_cycle"}, done_c, n + 1);
      check({tag, "_done_pulses"}, done_n, 1);
   endtask

   task automatic wait_code(input int g, input logic [4:0] code, input string tag);
      bit found;
      found = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (x_out_v[g] == code) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check({tag, "_reach"}, {31'd0, found}, 32'd1);
   endtask

   initial begin
      int done_n;
      n_checks = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         abort_v[i] = 1'b0;
         mode_v[i]  = 0;
      end
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         check("rst_x", {27'd0, x_out_v[i]}, 32'd0);
         check("rst_busy", {31'd0, busy_v[i]}, 32'd0);
         check("rst_done", {31'd0, done_v[i]}, 32'd0);
         check("rst_table", table_v[i], 32'd0);
         check("rst_ones", {26'd0, ones_v[i]}, 32'd0);
      end
      rst_n = 1'b1;
      tick();

      // Lagging model on fresh instances, then the plain functions.
      do_scan(1, 3, 1'b0, 1'b0, -1, "dly_s0");
      do_scan(2, 3, 1'b0, 1'b0, -1, "dly_s1");
      do_scan(0, 0, 1'b0, 1'b0, -1, "x0_s2");
      do_scan(1, 1, 1'b0, 1'b0, -1, "and_s0");
      do_scan(1, 2, 1'b0, 1'b0, -1, "ones_s0");

      // Abort while code 4 is settling.
      mode_v[0] = 0;
      sb.push_back(model(0, 0, 2, 1'b0, 4));
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      wait_code(0, 5'd4, "abort");
      check("abort_busy_before", {31'd0, busy_v[0]}, 32'd1);
      abort_v[0] = 1'b1;
      tick();
      abort_v[0] = 1'b0;
      check("abort_busy", {31'd0, busy_v[0]}, 32'd0);
      check("abort_x", {27'd0, x_out_v[0]}, 32'd0);
      done_n = 0;
      for (int c = 0; c < 6; c++) begin
         if (done_v[0]) done_n++;
         tick();
      end
      check("abort_no_done", done_n, 0);
      pop_compare(0, "abort");

      // Start and abort together in IDLE: nothing moves, partial table kept.
      start_v[0] = 1'b1;
      abort_v[0] = 1'b1;
      tick();
      tick();
      check("both_busy", {31'd0, busy_v[0]}, 32'd0);
      check("both_done", {31'd0, done_v[0]}, 32'd0);
      check("both_table", table_v[0], model(0, 0, 2, 1'b0, 4).tbl);
      start_v[0] = 1'b0;
      abort_v[0] = 1'b0;
      tick();

      // Start held through the scan and its done cycle, with an extra pulse at code 10.
      do_scan(0, 0, 1'b0, 1'b1, 10, "hold");

      // Asynchronous reset between edges while code 7 settles.
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      wait_code(0, 5'd7, "rst");
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_x", {27'd0, x_out_v[0]}, 32'd0);
      check("arst_busy", {31'd0, busy_v[0]}, 32'd0);
      check("arst_done", {31'd0, done_v[0]}, 32'd0);
      check("arst_table", table_v[0], 32'd0);
      check("arst_ones", {26'd0, ones_v[0]}, 32'd0);
      rst_n = 1'b1;
      tick();
      do_scan(0, 0, 1'b0, 1'b0, -1, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
